sec_b2a_n: RTL and testbench

- Converts an N-share Boolean-masked K-bit value (XOR of shares = X) into N-share arithmetic masking (sum of shares mod 2^K = X).
- Reverse direction of the masked A2B converter; sits at the Boolean-to-arithmetic boundary of the masked datapath.
- Iterative design: one shared SecKSA instance is reused N-1 times to subtract fresh random arithmetic shares from the Boolean value. A full refresh and an XOR-fold then produce the last arithmetic share.

---
 rtl/sec_b2a_n_if.sv | 21 ++
 rtl/sec_b2a_n.sv | 196 +++++++++++++++++++
 tb/tb_sec_b2a_n.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sec_b2a_n_if.sv
// Handshake/data bundle for sec_b2a_n: Boolean shares in, arithmetic shares out, plus randomness.
`timescale 1ns/1ps
interface sec_b2a_n_if #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 8
);
  localparam int MASKWIDTH = K_WIDTH * N_SHARES;
  localparam int RAND_KSA  = 2 * $clog2(K_WIDTH - 1) * N_SHARES * (N_SHARES - 1);
  localparam int RANDNUM   = RAND_KSA + 1 + N_SHARES * (N_SHARES - 1) / 2;

  logic                         dvld;
  logic                         ena;
  logic [RANDNUM*K_WIDTH-1:0]   rnd;
  logic [MASKWIDTH-1:0]         i_x;
  logic [MASKWIDTH-1:0]         o_z;
  logic                         ovld;
  logic                         o_busy;

  modport master (output dvld, ena, rnd, i_x, input o_z, ovld, o_busy);
  modport slave  (input dvld, ena, rnd, i_x, output o_z, ovld, o_busy);
endinterface

// File: rtl/sec_b2a_n.sv
// N-share Boolean-to-arithmetic mask converter; one pipelined SecKSA reused N-1 times.
// Optional SEC_B2A_ZEROIZE_EN: result and working shares are cleared after each conversion.
`timescale 1ns/1ps
module sec_b2a_n #(
  parameter int K_WIDTH   = 32,
  parameter int N_SHARES  = 8,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int RAND_KSA  = 2 * $clog2(K_WIDTH - 1) * N_SHARES * (N_SHARES - 1),
  parameter int RANDNUM   = RAND_KSA + 1 + N_SHARES * (N_SHARES - 1) / 2
) (
  input  logic        clk,
  input  logic        rst,
  sec_b2a_n_if.slave  bus
);
  localparam int unsigned NPAIR    = N_SHARES * (N_SHARES - 1) / 2;
  localparam int unsigned ROUNDS   = $clog2(K_WIDTH - 1);
  localparam int unsigned KSA_BASE = 1 + NPAIR;
  localparam int unsigned CW       = $clog2(N_SHARES);

  typedef logic [K_WIDTH-1:0]         word_t;
  typedef logic [MASKWIDTH-1:0]       shares_t;
  typedef logic [RANDNUM*K_WIDTH-1:0] rnd_t;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, REF, FOLD, DONE} state_t;

  function automatic word_t rword(input rnd_t rv, input int unsigned idx);
    return rv[idx*K_WIDTH +: K_WIDTH];
  endfunction

  function automatic shares_t shl(input shares_t a, input int unsigned d);
    shares_t s;
    s = '0;
    for (int unsigned i = 0; i < N_SHARES; i++)
      s[i*K_WIDTH +: K_WIDTH] = a[i*K_WIDTH +: K_WIDTH] << d;
    return s;
  endfunction

  // ISW multiplication: each pair (i<j) consumes one fresh word starting at rnd word 'base'.
  function automatic shares_t sec_and(input shares_t a, input shares_t b, input rnd_t rv,
                                      input int unsigned base);
    shares_t     c;
    word_t       r;
    int unsigned idx;
    c   = '0;
    idx = base;
    for (int unsigned i = 0; i < N_SHARES; i++)
      c[i*K_WIDTH +: K_WIDTH] = a[i*K_WIDTH +: K_WIDTH] & b[i*K_WIDTH +: K_WIDTH];
    for (int unsigned i = 0; i < N_SHARES; i++) begin
      for (int unsigned j = i + 1; j < N_SHARES; j++) begin
        r   = rword(rv, idx);
        idx = idx + 1;
        c[i*K_WIDTH +: K_WIDTH] = c[i*K_WIDTH +: K_WIDTH] ^ r;
        c[j*K_WIDTH +: K_WIDTH] = c[j*K_WIDTH +: K_WIDTH] ^ r
                                  ^ (a[i*K_WIDTH +: K_WIDTH] & b[j*K_WIDTH +: K_WIDTH])
                                  ^ (a[j*K_WIDTH +: K_WIDTH] & b[i*K_WIDTH +: K_WIDTH]);
      end
    end
    return c;
  endfunction

  function automatic shares_t sec_ref(input shares_t a, input rnd_t rv);
    shares_t     s;
    word_t       w;
    int unsigned idx;
    s   = a;
    idx = 1;
    for (int unsigned i = 0; i < N_SHARES; i++) begin
      for (int unsigned j = i + 1; j < N_SHARES; j++) begin
        w   = rword(rv, idx);
        idx = idx + 1;
        s[i*K_WIDTH +: K_WIDTH] = s[i*K_WIDTH +: K_WIDTH] ^ w;
        s[j*K_WIDTH +: K_WIDTH] = s[j*K_WIDTH +: K_WIDTH] ^ w;
      end
    end
    return s;
  endfunction

  function automatic word_t fold(input shares_t a);
    word_t f;
    f = '0;
    for (int unsigned i = 0; i < N_SHARES; i++) f = f ^ a[i*K_WIDTH +: K_WIDTH];
    return f;
  endfunction

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  shares_t        x_q, a_q, oz_q;
  logic           ovld_q, busy_q;

  rnd_t           rnd;
  word_t          r_w, neg_r;
  shares_t        ksa_y, ksa_z;
  shares_t        p_q  [ROUNDS+1];
  shares_t        g_q  [ROUNDS+1];
  shares_t        p0_q [ROUNDS+1];
  logic [ROUNDS:0] v_q;

  assign rnd   = bus.rnd;
  assign r_w   = rnd[K_WIDTH-1:0];
  assign neg_r = '0 - r_w;

  always_comb begin
    ksa_y              = '0;
    ksa_y[K_WIDTH-1:0] = neg_r;
  end

  // Generate terms combine with XOR: g and p of the same span are never both set.
  assign ksa_z = p0_q[ROUNDS] ^ shl(g_q[ROUNDS], 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned k = 0; k <= ROUNDS; k++) begin
        p_q[k]  <= '0;
        g_q[k]  <= '0;
        p0_q[k] <= '0;
      end
    end else if (bus.ena) begin
      v_q     <= {v_q[ROUNDS-1:0], (state_q == LAUNCH)};
      p_q[0]  <= x_q ^ ksa_y;
      p0_q[0] <= x_q ^ ksa_y;
      g_q[0]  <= sec_and(x_q, ksa_y, rnd, KSA_BASE);
      for (int unsigned k = 0; k < ROUNDS; k++) begin
        p0_q[k+1] <= p0_q[k];
        g_q[k+1]  <= g_q[k] ^ sec_and(p_q[k], shl(g_q[k], 32'd1 << k), rnd,
                                      KSA_BASE + (1 + 2*k) * NPAIR);
        p_q[k+1]  <= sec_and(p_q[k], shl(p_q[k], 32'd1 << k), rnd,
                             KSA_BASE + (2 + 2*k) * NPAIR);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      a_q     <= '0;
      oz_q    <= '0;
      ovld_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.ena) begin
      ovld_q <= 1'b0;
`ifdef SEC_B2A_ZEROIZE_EN
      if (ovld_q) oz_q <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.dvld) begin
            x_q     <= bus.i_x;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          a_q[cnt_q*K_WIDTH +: K_WIDTH] <= r_w;
          state_q <= WAIT;
        end
        WAIT: begin
          if (v_q[ROUNDS]) begin
            x_q <= ksa_z;
            if (cnt_q == CW'(N_SHARES - 1)) begin
              state_q <= REF;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= LAUNCH;
            end
          end
        end
        REF: begin
          x_q     <= sec_ref(x_q, rnd);
          state_q <= FOLD;
        end
        FOLD: begin
          a_q[K_WIDTH-1:0] <= fold(x_q);
          state_q          <= DONE;
        end
        DONE: begin
          oz_q    <= a_q;
          ovld_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef SEC_B2A_ZEROIZE_EN
          x_q     <= '0;
          a_q     <= '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_z    = oz_q;
  assign bus.ovld   = ovld_q;
  assign bus.o_busy = busy_q;
endmodule

// File: tb/tb_sec_b2a_n.sv
// Directed bench for sec_b2a_n: vector table plus reset, dvld-hold, ena-freeze and random-invariant sequences.
`timescale 1ns/1ps
module tb_sec_b2a_n;
  localparam int K       = 32;
  localparam int N       = 8;
  localparam int MW      = K * N;
  localparam int NP      = N * (N - 1) / 2;
  localparam int RANDNUM = 2 * $clog2(K - 1) * N * (N - 1) + 1 + NP;
  localparam int LAT     = 52;

  typedef logic [MW-1:0]        sh_t;
  typedef logic [K-1:0]         w_t;
  typedef logic [RANDNUM*K-1:0] rv_t;

  typedef struct {
    string name;
    sh_t   x;
    w_t    r;
    w_t    fill;
    w_t    exp0;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  sec_b2a_n_if #(.K_WIDTH(K), .N_SHARES(N)) bus ();
  sec_b2a_n #(.K_WIDTH(K), .N_SHARES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input sh_t act, input sh_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic rv_t mk_rnd(input w_t r, input w_t fill);
    rv_t v;
    w_t  t;
    v      = '0;
    v[K-1:0] = r;
    for (int w = 1; w < RANDNUM; w++) begin
      t = w_t'(w) * 32'h9E3779B9;
      v[w*K +: K] = (fill == '0) ? '0 : (fill ^ t);
    end
    return v;
  endfunction

  function automatic rv_t rand_rnd();
    rv_t v;
    for (int w = 0; w < RANDNUM; w++) v[w*K +: K] = $urandom();
    return v;
  endfunction

  function automatic sh_t rand_x();
    sh_t v;
    for (int i = 0; i < N; i++) v[i*K +: K] = $urandom();
    return v;
  endfunction

  function automatic w_t xor_sh(input sh_t a);
    w_t f = '0;
    for (int i = 0; i < N; i++) f = f ^ a[i*K +: K];
    return f;
  endfunction

  function automatic w_t sum_sh(input sh_t a);
    w_t f = '0;
    for (int i = 0; i < N; i++) f = f + a[i*K +: K];
    return f;
  endfunction

  function automatic sh_t exp_of(input vec_t v);
    sh_t e;
    e = {N{v.r}};
    e[K-1:0] = v.exp0;
    return e;
  endfunction

  task automatic wait_ovld(input bit rr, output int n);
    n = 0;
    while (bus.ovld !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (rr) bus.rnd = rand_rnd();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    sh_t got;
    @(negedge clk);
    bus.i_x  = v.x;
    bus.rnd  = mk_rnd(v.r, v.fill);
    bus.dvld = 1'b1;
    @(negedge clk);
    bus.dvld = 1'b0;
    chk({v.name, " busy"}, sh_t'(bus.o_busy), sh_t'(1));
    wait_ovld(1'b0, n);
    chk({v.name, " latency"}, sh_t'(n), sh_t'(LAT));
    got = bus.o_z;
    chk({v.name, " o_z"}, got, exp_of(v));
    chk({v.name, " sum"}, sh_t'(sum_sh(got)), sh_t'(xor_sh(v.x)));
    chk({v.name, " idle"}, sh_t'(bus.o_busy), sh_t'(0));
    @(negedge clk);
    chk({v.name, " pulse"}, sh_t'(bus.ovld), sh_t'(0));
`ifdef SEC_B2A_ZEROIZE_EN
    chk({v.name, " clear"}, bus.o_z, '0);
`else
    chk({v.name, " hold"}, bus.o_z, exp_of(v));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int  n, first, hi;
    sh_t oz, xr, x5;

    for (int i = 0; i < N; i++) x5[i*K +: K] = w_t'(i);
    vecs[0] = '{"deadbeef", sh_t'(32'hDEADBEEF), 32'h00000001, 32'h0, 32'hDEADBEE8};
    vecs[1] = '{"wrap",     {N{32'h12345678}},   32'hFFFFFFFF, 32'h0, 32'h00000007};
    vecs[2] = '{"r_zero",   sh_t'(32'hFFFFFFFF), 32'h00000000, 32'hA5A5A5A5, 32'hFFFFFFFF};
    vecs[3] = '{"two_sh",   sh_t'({32'hF0F0F0F0, 32'h0F0F0F0F}), 32'h10000000, 32'h5A5A5A5A, 32'h8FFFFFFF};
    vecs[4] = '{"msb_r",    {32'h0, {(N-1){32'h00000001}}}, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};
    vecs[5] = '{"idx_sh",   x5, 32'h00000003, 32'h13572468, 32'hFFFFFFEB};

    rst      = 1'b1;
    bus.dvld = 1'b0;
    bus.ena  = 1'b1;
    bus.i_x  = '0;
    bus.rnd  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset o_z", bus.o_z, '0);
    chk("reset ovld", sh_t'(bus.ovld), sh_t'(0));
    chk("reset busy", sh_t'(bus.o_busy), sh_t'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // reset while the KSA is in flight
    @(negedge clk);
    bus.i_x  = vecs[2].x;
    bus.rnd  = mk_rnd(vecs[3].r, vecs[3].fill);
    bus.dvld = 1'b1;
    @(negedge clk);
    bus.dvld = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", sh_t'(bus.o_busy), sh_t'(0));
    chk("midrst ovld", sh_t'(bus.ovld), sh_t'(0));
    chk("midrst o_z", bus.o_z, '0);
    run_vec(vecs[0]);

    // dvld held high
    @(negedge clk);
    bus.i_x  = vecs[4].x;
    bus.rnd  = mk_rnd(vecs[4].r, vecs[4].fill);
    bus.dvld = 1'b1;
    @(negedge clk);
    wait_ovld(1'b0, n);
    chk("hold first latency", sh_t'(n), sh_t'(LAT));
    chk("hold first o_z", bus.o_z, exp_of(vecs[4]));
    @(negedge clk);
    chk("hold reaccept busy", sh_t'(bus.o_busy), sh_t'(1));
    chk("hold no dup ovld", sh_t'(bus.ovld), sh_t'(0));
    wait_ovld(1'b0, n);
    chk("hold spacing", sh_t'(n + 1), sh_t'(LAT + 1));
    chk("hold second o_z", bus.o_z, exp_of(vecs[4]));
    bus.dvld = 1'b0;
    @(negedge clk);
    chk("hold stop busy", sh_t'(bus.o_busy), sh_t'(0));

    // ena freezes in LAUNCH, WAIT, DONE, then during the ovld pulse
    @(negedge clk);
    bus.i_x  = vecs[3].x;
    bus.rnd  = mk_rnd(vecs[3].r, vecs[3].fill);
    bus.dvld = 1'b1;
    @(negedge clk);
    bus.dvld = 1'b0;
    first = -1;
    hi    = 0;
    oz    = '0;
    for (int k = 0; k < 100; k++) begin
      if (bus.ovld === 1'b1) begin
        hi++;
        if (first < 0) begin
          first = k;
          oz    = bus.o_z;
        end
      end
      bus.ena = !((k < 5) || (k >= 10 && k < 15) || (k >= 61 && k < 66) || (k >= 67 && k < 70));
      @(negedge clk);
    end
    bus.ena = 1'b1;
    chk("ena latency", sh_t'(first), sh_t'(LAT + 15));
    chk("ena ovld cycles", sh_t'(hi), sh_t'(4));
    chk("ena o_z", oz, exp_of(vecs[3]));

    // random shares with fresh randomness every cycle
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      xr       = rand_x();
      bus.i_x  = xr;
      bus.rnd  = rand_rnd();
      bus.dvld = 1'b1;
      @(negedge clk);
      bus.dvld = 1'b0;
      bus.i_x  = rand_x();
      wait_ovld(1'b1, n);
      chk("rand latency", sh_t'(n), sh_t'(LAT));
      chk("rand invariant", sh_t'(sum_sh(bus.o_z)), sh_t'(xor_sh(xr)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
